fios_res_collector: RTL and testbench

- Sits directly downstream of the FIOS multiplier top level. Captures the s result words streamed out on its RES_push/RES output, framed by its done pulse.
- Stores each complete Montgomery product in one of two banks (ping-pong), so the multiplier can run product N+1 while product N drains.
- Drains each product LSW-first over a valid/ready stream to the next consumer (host FIFO / next-operation loader).
- Flags protocol violations: wrong word count, overrun.

---
 rtl/fios_pkg.sv | 10 +
 rtl/fios_res_bank.sv | 52 +++++
 rtl/fios_res_collector.sv | 157 +++++++++++++++
 tb/tb_fios_res_collector.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fios_pkg.sv
// Shared definitions for the FIOS result collector: word width and read-side states.
package fios_pkg;
  localparam int WORD_W = 17;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    STREAM = 2'd2
  } rd_state_t;
endpackage

// File: rtl/fios_res_bank.sv
// Two-bank result store: one write port, one read port with an output register
// that holds its value until the next read enable.
module fios_res_bank
  import fios_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              srst,
  input  logic              we,
  input  logic              wr_bank,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WORD_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic              rd_bank,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WORD_W-1:0] rd_data
);
  logic [1:0][WORD_W-1:0] rd_word;
  logic [WORD_W-1:0]      rd_data_d;
  logic [WORD_W-1:0]      rd_data_q;

  for (genvar gi = 0; gi < 2; gi++) begin : g_bank
    logic [WORD_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
      if (we && (wr_bank == 1'(gi))) begin
        mem_q[wr_addr] <= wr_data;
      end
    end

    assign rd_word[gi] = mem_q[rd_addr];
  end

  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) begin
      rd_data_d = rd_word[rd_bank];
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;
endmodule

// File: rtl/fios_res_collector.sv
// Captures s-word Montgomery products into ping-pong banks and drains them
// LSW-first over a valid/ready stream, flagging framing and overrun errors.
module fios_res_collector
  import fios_pkg::*;
#(
  parameter  int s     = 8,
  localparam int IDX_W = $clog2(s + 1)
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              RES_push_i,
  input  logic [WORD_W-1:0] RES_i,
  input  logic              done_i,
  output logic              slot_free_o,
  output logic              res_valid_o,
  input  logic              res_ready_i,
  output logic [WORD_W-1:0] res_data_o,
  output logic [IDX_W-1:0]  res_idx_o,
  output logic              res_last_o,
  output logic              err_o,
  input  logic              err_clear_i
);
  localparam int                ADDR_W    = $clog2(s);
  localparam logic [IDX_W-1:0]  WORD_CNT  = IDX_W'(s);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(s - 1);

  logic [1:0]        full_q, full_d, full_set, full_clr;
  logic              wr_bank_q, wr_bank_d;
  logic [IDX_W-1:0]  wr_idx_q, wr_idx_d, eff_cnt;
  logic              rd_bank_q, rd_bank_d;
  logic [ADDR_W-1:0] rd_idx_q, rd_idx_d, rd_addr;
  rd_state_t         state_q, state_d;
  logic              valid_q, valid_d;
  logic              err_q, err_d;
  logic              slot_free_q, slot_free_d;
  logic              push_ok, push_err, done_err, handshake, rd_en;

  // Write side: a push lands only into an empty bank with room left.
  always_comb begin
    push_ok   = RES_push_i && (wr_idx_q < WORD_CNT) && !full_q[wr_bank_q];
    push_err  = RES_push_i && !push_ok;
    eff_cnt   = wr_idx_q + IDX_W'(push_ok);
    wr_idx_d  = eff_cnt;
    wr_bank_d = wr_bank_q;
    full_set  = '0;
    done_err  = 1'b0;
    if (done_i) begin
      wr_idx_d = '0;
      if (eff_cnt == WORD_CNT) begin
        full_set[wr_bank_q] = 1'b1;
        wr_bank_d           = ~wr_bank_q;
      end else begin
        done_err = 1'b1;
      end
    end
  end

  // Read side: the RAM output register doubles as the output data register,
  // so each accepted word triggers the read of the next one.
  always_comb begin
    state_d   = state_q;
    rd_idx_d  = rd_idx_q;
    rd_bank_d = rd_bank_q;
    valid_d   = valid_q;
    full_clr  = '0;
    rd_en     = 1'b0;
    rd_addr   = rd_idx_q;
    handshake = valid_q && res_ready_i;
    case (state_q)
      IDLE: begin
        if (full_q[rd_bank_q]) begin
          state_d  = LOAD;
          rd_idx_d = '0;
        end
      end
      LOAD: begin
        rd_en   = 1'b1;
        valid_d = 1'b1;
        state_d = STREAM;
      end
      STREAM: begin
        if (handshake) begin
          if (rd_idx_q == LAST_ADDR) begin
            full_clr[rd_bank_q] = 1'b1;
            rd_bank_d           = ~rd_bank_q;
            rd_idx_d            = '0;
            valid_d             = 1'b0;
            state_d             = full_q[~rd_bank_q] ? LOAD : IDLE;
          end else begin
            rd_idx_d = rd_idx_q + ADDR_W'(1);
            rd_addr  = rd_idx_q + ADDR_W'(1);
            rd_en    = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    full_d      = (full_q & ~full_clr) | full_set;
    slot_free_d = !full_d[wr_bank_d] && (wr_idx_d == '0);
    err_d       = err_q;
    if (err_clear_i) begin
      err_d = 1'b0;
    end
    if (push_err || done_err) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      full_q      <= '0;
      wr_bank_q   <= 1'b0;
      wr_idx_q    <= '0;
      rd_bank_q   <= 1'b0;
      rd_idx_q    <= '0;
      state_q     <= IDLE;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
      slot_free_q <= 1'b1;
    end else begin
      full_q      <= full_d;
      wr_bank_q   <= wr_bank_d;
      wr_idx_q    <= wr_idx_d;
      rd_bank_q   <= rd_bank_d;
      rd_idx_q    <= rd_idx_d;
      state_q     <= state_d;
      valid_q     <= valid_d;
      err_q       <= err_d;
      slot_free_q <= slot_free_d;
    end
  end

  fios_res_bank #(
    .DEPTH  (s),
    .ADDR_W (ADDR_W)
  ) u_bank (
    .clk     (clock_i),
    .srst    (reset_i),
    .we      (push_ok),
    .wr_bank (wr_bank_q),
    .wr_addr (wr_idx_q[ADDR_W-1:0]),
    .wr_data (RES_i),
    .rd_en   (rd_en),
    .rd_bank (rd_bank_q),
    .rd_addr (rd_addr),
    .rd_data (res_data_o)
  );

  assign res_valid_o = valid_q;
  assign res_idx_o   = IDX_W'(rd_idx_q);
  assign res_last_o  = valid_q && (rd_idx_q == LAST_ADDR);
  assign slot_free_o = slot_free_q;
  assign err_o       = err_q;
endmodule

// File: tb/tb_fios_res_collector.sv
// Bench for fios_res_collector (s = 4): directed table, corner sequences and
// random traffic, all checked against a product-queue reference model.
module tb_fios_res_collector;
  localparam int S  = 4;
  localparam int IW = $clog2(S + 1);

  logic          clk = 1'b0;
  logic          reset_i = 1'b1;
  logic          RES_push_i = 1'b0;
  logic [16:0]   RES_i = '0;
  logic          done_i = 1'b0;
  logic          res_ready_i = 1'b0;
  logic          err_clear_i = 1'b0;
  logic          slot_free_o, res_valid_o, res_last_o, err_o;
  logic [16:0]   res_data_o;
  logic [IW-1:0] res_idx_o;

  int assert_cnt = 0;
  int fail_cnt   = 0;

  // Reference model: finished products as a flat word queue, plus counts.
  int exp_q[$];
  int cur_q[$];
  int m_wcnt = 0, m_nfull = 0, m_oidx = 0, wait_cnt = 0;
  bit m_err = 1'b0, m_slot = 1'b1;

  typedef struct {
    logic          push;
    logic [16:0]   data;
    logic          done;
    logic          ready;
    logic          ev;
    logic [16:0]   ed;
    logic [IW-1:0] ei;
    logic          el;
    logic          es;
    logic          ee;
  } vec_t;
  vec_t tbl[10];

  fios_res_collector #(.s(S)) dut (
    .clock_i     (clk),
    .reset_i     (reset_i),
    .RES_push_i  (RES_push_i),
    .RES_i       (RES_i),
    .done_i      (done_i),
    .slot_free_o (slot_free_o),
    .res_valid_o (res_valid_o),
    .res_ready_i (res_ready_i),
    .res_data_o  (res_data_o),
    .res_idx_o   (res_idx_o),
    .res_last_o  (res_last_o),
    .err_o       (err_o),
    .err_clear_i (err_clear_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    assert_cnt++;
    if (got !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got %0h required %0h", name, got, exp);
    end
  endtask

  task automatic step();
    logic          hs, stall, pok, perr, derr;
    logic [16:0]   sd;
    logic [IW-1:0] si;
    hs = 1'b0; stall = 1'b0; perr = 1'b0; derr = 1'b0;
    sd = res_data_o; si = res_idx_o;
    if (reset_i) begin
      exp_q.delete(); cur_q.delete();
      m_wcnt = 0; m_nfull = 0; m_oidx = 0; m_err = 1'b0; wait_cnt = 0;
    end else begin
      hs    = res_valid_o && res_ready_i;
      stall = res_valid_o && !res_ready_i;
      pok   = RES_push_i && (m_wcnt < S) && (m_nfull < 2);
      perr  = RES_push_i && !pok;
      if (pok) begin
        cur_q.push_back(int'(RES_i));
        m_wcnt++;
      end
      if (hs) begin
        $display("xfer idx=%0d data=%05h last=%0d", res_idx_o, res_data_o, res_last_o);
        if (exp_q.size() == 0) begin
          chk("phantom_word", 32'(1), 32'(0));
        end else begin
          chk("xfer_data", 32'(res_data_o), 32'(exp_q[0]));
          chk("xfer_idx", 32'(res_idx_o), 32'(m_oidx));
          void'(exp_q.pop_front());
        end
        if (m_oidx == S - 1) begin
          m_oidx = 0;
          m_nfull--;
        end else begin
          m_oidx++;
        end
      end
      if (done_i) begin
        if (m_wcnt == S) begin
          foreach (cur_q[k]) exp_q.push_back(cur_q[k]);
          m_nfull++;
        end else begin
          derr = 1'b1;
        end
        cur_q.delete();
        m_wcnt = 0;
      end
      if (perr || derr) m_err = 1'b1;
      else if (err_clear_i) m_err = 1'b0;
    end
    m_slot = (m_nfull < 2) && (m_wcnt == 0);
    @(posedge clk);
    #1;
    chk("err_o", 32'(err_o), 32'(m_err));
    chk("slot_free_o", 32'(slot_free_o), 32'(m_slot));
    if (!reset_i) begin
      if (stall) begin
        chk("hold_valid", 32'(res_valid_o), 32'(1));
        chk("hold_data", 32'(res_data_o), 32'(sd));
        chk("hold_idx", 32'(res_idx_o), 32'(si));
      end
      if (res_valid_o) begin
        chk("last_flag", 32'(res_last_o), 32'(m_oidx == S - 1));
        chk("valid_has_data", 32'(exp_q.size() > 0), 32'(1));
      end else begin
        chk("last_idle", 32'(res_last_o), 32'(0));
      end
      if (m_nfull > 0 && !res_valid_o) wait_cnt++;
      else wait_cnt = 0;
      chk("valid_latency", 32'(wait_cnt <= 2), 32'(1));
    end
  endtask

  task automatic cyc(input logic p, input logic [16:0] d, input logic dn, input logic rdy);
    RES_push_i  = p;
    RES_i       = d;
    done_i      = dn;
    res_ready_i = rdy;
    step();
  endtask

  task automatic push_prod(input logic [16:0] base, input logic rdy);
    for (int i = 0; i < S; i++) cyc(1'b1, base + 17'(i), (i == S - 1), rdy);
  endtask

  task automatic drain(input string name);
    for (int c = 0; c < 40; c++) begin
      if (exp_q.size() == 0 && !res_valid_o) break;
      cyc(1'b0, 17'h0, 1'b0, 1'b1);
    end
    chk(name, 32'(exp_q.size()), 32'(0));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    logic p, dn;

    tbl[0] = '{1'b1, 17'h00001, 1'b0, 1'b1, 1'b0, 17'h0,     3'd0, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 17'h00002, 1'b0, 1'b1, 1'b0, 17'h0,     3'd0, 1'b0, 1'b0, 1'b0};
    tbl[2] = '{1'b1, 17'h00003, 1'b0, 1'b1, 1'b0, 17'h0,     3'd0, 1'b0, 1'b0, 1'b0};
    tbl[3] = '{1'b1, 17'h1FFFF, 1'b1, 1'b1, 1'b0, 17'h0,     3'd0, 1'b0, 1'b1, 1'b0};
    tbl[4] = '{1'b0, 17'h00000, 1'b0, 1'b1, 1'b0, 17'h0,     3'd0, 1'b0, 1'b1, 1'b0};
    tbl[5] = '{1'b0, 17'h00000, 1'b0, 1'b1, 1'b1, 17'h00001, 3'd0, 1'b0, 1'b1, 1'b0};
    tbl[6] = '{1'b0, 17'h00000, 1'b0, 1'b1, 1'b1, 17'h00002, 3'd1, 1'b0, 1'b1, 1'b0};
    tbl[7] = '{1'b0, 17'h00000, 1'b0, 1'b1, 1'b1, 17'h00003, 3'd2, 1'b0, 1'b1, 1'b0};
    tbl[8] = '{1'b0, 17'h00000, 1'b0, 1'b1, 1'b1, 17'h1FFFF, 3'd3, 1'b1, 1'b1, 1'b0};
    tbl[9] = '{1'b0, 17'h00000, 1'b0, 1'b1, 1'b0, 17'h0,     3'd0, 1'b0, 1'b1, 1'b0};

    step();
    step();
    reset_i = 1'b0;
    chk("rst_valid", 32'(res_valid_o), 32'(0));
    chk("rst_data", 32'(res_data_o), 32'(0));
    chk("rst_idx", 32'(res_idx_o), 32'(0));
    chk("rst_last", 32'(res_last_o), 32'(0));
    chk("rst_slot_free", 32'(slot_free_o), 32'(1));
    chk("rst_err", 32'(err_o), 32'(0));

    // Single product, consumer always ready: valid two edges after done.
    for (int i = 0; i < 10; i++) begin
      cyc(tbl[i].push, tbl[i].data, tbl[i].done, tbl[i].ready);
      chk("tbl_valid", 32'(res_valid_o), 32'(tbl[i].ev));
      chk("tbl_last", 32'(res_last_o), 32'(tbl[i].el));
      chk("tbl_slot", 32'(slot_free_o), 32'(tbl[i].es));
      chk("tbl_err", 32'(err_o), 32'(tbl[i].ee));
      if (tbl[i].ev) begin
        chk("tbl_data", 32'(res_data_o), 32'(tbl[i].ed));
        chk("tbl_idx", 32'(res_idx_o), 32'(tbl[i].ei));
      end
    end

    // Back-pressure with ready pattern 1,0,0,1.
    push_prod(17'h00100, 1'b1);
    for (int c = 0; c < 40; c++) begin
      if (exp_q.size() == 0 && !res_valid_o) break;
      cyc(1'b0, 17'h0, 1'b0, (c % 4 == 0) || (c % 4 == 3));
    end
    chk("bp_drained", 32'(exp_q.size()), 32'(0));

    // Ping-pong with stalled consumer, then an overrun push.
    push_prod(17'h0A000, 1'b0);
    push_prod(17'h0B000, 1'b0);
    for (int c = 0; c < 3; c++) cyc(1'b0, 17'h0, 1'b0, 1'b0);
    chk("pp_slot_full", 32'(slot_free_o), 32'(0));
    chk("pp_valid", 32'(res_valid_o), 32'(1));
    chk("pp_head", 32'(res_data_o), 32'h0A000);
    cyc(1'b1, 17'h15555, 1'b0, 1'b0);
    chk("overrun_err", 32'(err_o), 32'(1));
    found = 1'b0;
    for (int c = 0; c < 20; c++) begin
      cyc(1'b0, 17'h0, 1'b0, 1'b1);
      if (exp_q.size() == S) begin
        found = 1'b1;
        break;
      end
    end
    chk("pp_a_drained", 32'(found), 32'(1));
    chk("pp_slot_after_a", 32'(slot_free_o), 32'(1));
    drain("pp_drained");
    err_clear_i = 1'b1;
    cyc(1'b0, 17'h0, 1'b0, 1'b1);
    err_clear_i = 1'b0;
    chk("pp_err_cleared", 32'(err_o), 32'(0));

    // Short product is discarded and flagged.
    for (int i = 0; i < 3; i++) cyc(1'b1, 17'h00700 + 17'(i), 1'b0, 1'b1);
    cyc(1'b0, 17'h0, 1'b1, 1'b1);
    chk("short_err", 32'(err_o), 32'(1));
    for (int c = 0; c < 4; c++) begin
      cyc(1'b0, 17'h0, 1'b0, 1'b1);
      chk("short_no_valid", 32'(res_valid_o), 32'(0));
    end
    err_clear_i = 1'b1;
    cyc(1'b0, 17'h0, 1'b0, 1'b1);
    err_clear_i = 1'b0;
    chk("short_err_cleared", 32'(err_o), 32'(0));
    push_prod(17'h0C000, 1'b1);
    drain("short_next_drained");

    // Reset in the middle of a drain.
    push_prod(17'h0D000, 1'b1);
    found = 1'b0;
    for (int c = 0; c < 20; c++) begin
      cyc(1'b0, 17'h0, 1'b0, 1'b1);
      if (res_valid_o && res_idx_o == 3'd2) begin
        found = 1'b1;
        break;
      end
    end
    chk("reach_idx2", 32'(found), 32'(1));
    reset_i = 1'b1;
    cyc(1'b0, 17'h0, 1'b0, 1'b1);
    reset_i = 1'b0;
    chk("mid_rst_valid", 32'(res_valid_o), 32'(0));
    chk("mid_rst_slot", 32'(slot_free_o), 32'(1));
    chk("mid_rst_err", 32'(err_o), 32'(0));
    push_prod(17'h0E000, 1'b1);
    drain("post_rst_drained");

    // Random traffic against the model.
    for (int c = 0; c < 800; c++) begin
      p = ($urandom % 4) != 0;
      if (m_wcnt + int'(p) == S) dn = ($urandom % 16) != 0;
      else dn = ($urandom % 40) == 0;
      err_clear_i = ($urandom % 20) == 0;
      cyc(p, 17'($urandom), dn, ($urandom % 3) != 0);
    end
    err_clear_i = 1'b0;
    drain("rand_drained");

    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end
endmodule
